modmul_stream_ctrl: RTL and testbench
=====================================

# modmul_stream_ctrl

Byte-stream front/back end for the modular multiplier core. Assembles two WIDTH-bit operands from a received byte stream and issues them to the multiplier with a single-cycle start pulse. Captures the result, serialises it as bytes over a valid/ready transmit handshake, and reports overrun and timeout faults. Sits between the UART receive/transmit blocks and the multiplier core in the FPGA top level.

## Interface
- WIDTH, 256, operand/result width in bits; multiple of 8, ≥16
- TIMEOUT, 4096, max cycles in WAIT before abandoning a job; ≥2
- clock  in  1  system clock; all logic on rising edge
- reset_all  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid this cycle (no back-pressure)
- mul_x  out  WIDTH  operand X to multiplier
- mul_y  out  WIDTH  operand Y to multiplier
- mul_in_valid  out  1  one-cycle start pulse
- mul_out_valid  in  1  multiplier result valid
- mul_q  in  WIDTH  multiplier result
- tx_data  out  8  byte to transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- busy  out  1  high in any state other than LOAD_X
- overrun  out  1  sticky: byte received while not loading
- timeout  out  1  sticky: job abandoned in WAIT
- job_count  out  16  completed jobs, wraps at 65535→0

## Operation
- NB = WIDTH/8. Byte counter runs 0..NB-1, shared by load and send phases.
- States: LOAD_X, LOAD_Y, ISSUE, WAIT, SEND.
- LOAD_X: each rx_valid cycle writes rx_data into mul_x[8k+7:8k], where k is the byte counter; the first byte is the LSB. After byte NB-1, clear the counter and go to LOAD_Y.
- LOAD_Y: loads mul_y the same way. After byte NB-1, go to ISSUE.
- ISSUE: mul_in_valid=1 for exactly this cycle. Clear the wait counter. Go to WAIT.
- WAIT: the wait counter increments each cycle.
  - On mul_out_valid: latch mul_q into the result shift register and go to SEND.
  - Otherwise, if the counter reaches TIMEOUT-1: set timeout and go to LOAD_X with the job discarded. job_count does not increment.
- SEND: tx_valid=1 and tx_data = result[7:0]. Each cycle with tx_valid && tx_ready, shift the result right by 8 and increment the byte counter. On the NB-th handshake: increment job_count, clear the counter, go to LOAD_X.
- rx_valid while in ISSUE, WAIT or SEND: byte dropped, overrun set.
- mul_out_valid outside WAIT (including the ISSUE cycle): ignored.
- mul_x and mul_y are only written in LOAD_X and LOAD_Y. They hold stable from ISSUE until overwritten by the next job.
- overrun and timeout clear only on reset_all.

## Timing
- Reset values: state LOAD_X, byte counter 0, mul_x=0, mul_y=0, mul_in_valid=0, tx_valid=0, tx_data=0, busy=0, overrun=0, timeout=0, job_count=0.
- reset_all asserted in any state: all of the above are restored the next cycle, and any in-flight job is abandoned without a tx byte.
- Last Y byte accepted in cycle t: ISSUE (mul_in_valid=1) in cycle t+1, WAIT from t+2.
- mul_out_valid sampled in cycle u of WAIT: tx_valid=1 with the LSB byte from u+1.
- tx_data and tx_valid hold stable while tx_valid && !tx_ready.
- Final handshake in cycle v: LOAD_X from v+1, with tx_valid=0 and busy=0. A byte presented at v+1 is accepted as X byte 0.
- All outputs are registered. No combinational path from inputs to outputs.
- Minimum job length: 2·NB + 2 + (multiplier latency) + NB cycles.

## Test plan
- Reset: hold reset_all 3 cycles → every output at its reset value. busy=0. tx_valid stays 0 for 10 further idle cycles.
- Single job, WIDTH=16:
  - Bytes 0x34,0x12 (X=0x1234), then 0x78,0x56 (Y=0x5678) → mul_in_valid pulses once, 1 cycle after the last byte.
  - Model returns mul_q=0xBEEF after 5 cycles, tx_ready=1 → tx bytes 0xEF, 0xBE. job_count=1. busy drops the cycle after the 2nd handshake.
- Back-pressure: as above, with tx_ready toggling 0,0,1,0,1 → tx_data is held through the stalls. Exactly 2 handshakes, bytes 0xEF then 0xBE.
- Overrun: pulse rx_valid with 0xAA during WAIT → overrun=1 and stays 1. mul_x/mul_y are unchanged. The job completes normally.
- Timeout, TIMEOUT=8: model never asserts mul_out_valid → timeout=1 on the 8th WAIT cycle and state returns to LOAD_X. job_count is unchanged. A following full job completes correctly.
- Reset mid-SEND: assert reset_all after the first tx handshake → tx_valid=0 next cycle and job_count=0. The next 4 received bytes start a fresh job.

Source files
------------

// File: rtl/modmul_stream_ctrl_if.sv
// Bundle of the byte-stream, multiplier and status signals around modmul_stream_ctrl.
// master = the controller, slave = the surrounding UART/multiplier environment.
`timescale 1ns/1ps
interface modmul_stream_ctrl_if #(
    parameter int WIDTH = 256
);
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [WIDTH-1:0] mul_x;
    logic [WIDTH-1:0] mul_y;
    logic             mul_in_valid;
    logic             mul_out_valid;
    logic [WIDTH-1:0] mul_q;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic             overrun;
    logic             timeout;
    logic [15:0]      job_count;
    logic [2:0]       state_dbg;

    // Handshakes: rx_valid has no back-pressure; a tx byte moves on a cycle where
    // tx_valid && tx_ready, and tx_data/tx_valid hold while tx_valid && !tx_ready.
    modport master (
        input  rx_data, rx_valid, mul_out_valid, mul_q, tx_ready,
        output mul_x, mul_y, mul_in_valid, tx_data, tx_valid,
        output busy, overrun, timeout, job_count, state_dbg
    );

    modport slave (
        output rx_data, rx_valid, mul_out_valid, mul_q, tx_ready,
        input  mul_x, mul_y, mul_in_valid, tx_data, tx_valid,
        input  busy, overrun, timeout, job_count, state_dbg
    );
endinterface

// File: rtl/modmul_stream_ctrl.sv
// Assembles two WIDTH-bit operands from received bytes, starts the multiplier,
// then streams the result back out LSB-first with overrun/timeout fault flags.
`timescale 1ns/1ps
module modmul_stream_ctrl #(
    parameter int WIDTH   = 256,
    parameter int TIMEOUT = 4096
) (
    input  logic                  clock,
    input  logic                  reset_all,
    modmul_stream_ctrl_if.master  bus
);
    localparam int NB     = WIDTH / 8;
    localparam int CNT_W  = $clog2(NB);
    localparam int WAIT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_LOAD_X = 3'd0,
        S_LOAD_Y = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_SEND   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [WIDTH-1:0] mul_x_q, mul_x_d;
    logic [WIDTH-1:0] mul_y_q, mul_y_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic [15:0]      job_count_q, job_count_d;

    logic last_byte;
    assign last_byte = (byte_cnt_q == CNT_W'(NB - 1));

    always_ff @(posedge clock) begin
        if (reset_all) begin
            state_q     <= S_LOAD_X;
            byte_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            mul_x_q     <= '0;
            mul_y_q     <= '0;
            result_q    <= '0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
            job_count_q <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mul_x_q     <= mul_x_d;
            mul_y_q     <= mul_y_d;
            result_q    <= result_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
            job_count_q <= job_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        mul_x_d     = mul_x_q;
        mul_y_d     = mul_y_q;
        result_d    = result_q;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;
        job_count_d = job_count_q;

        // Bytes arriving outside the load phases are dropped and flagged.
        if (bus.rx_valid && (state_q == S_ISSUE || state_q == S_WAIT || state_q == S_SEND)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_LOAD_X: begin
                if (bus.rx_valid) begin
                    mul_x_d[8*byte_cnt_q +: 8] = bus.rx_data;
                    if (last_byte) begin
                        byte_cnt_d = '0;
                        state_d    = S_LOAD_Y;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_LOAD_Y: begin
                if (bus.rx_valid) begin
                    mul_y_d[8*byte_cnt_q +: 8] = bus.rx_data;
                    if (last_byte) begin
                        byte_cnt_d = '0;
                        state_d    = S_ISSUE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mul_out_valid) begin
                    result_d = bus.mul_q;
                    state_d  = S_SEND;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_LOAD_X;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_SEND: begin
                // The result only shifts on a handshake, so a stalled byte stays put.
                if (bus.tx_ready) begin
                    result_d = result_q >> 8;
                    if (last_byte) begin
                        byte_cnt_d  = '0;
                        job_count_d = job_count_q + 16'd1;
                        state_d     = S_LOAD_X;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_LOAD_X;
            end
        endcase
    end

    // Every output decodes straight from flops; nothing passes combinationally from inputs.
    assign bus.mul_x        = mul_x_q;
    assign bus.mul_y        = mul_y_q;
    assign bus.mul_in_valid = (state_q == S_ISSUE);
    assign bus.tx_valid     = (state_q == S_SEND);
    assign bus.tx_data      = result_q[7:0];
    assign bus.busy         = (state_q != S_LOAD_X);
    assign bus.overrun      = overrun_q;
    assign bus.timeout      = timeout_q;
    assign bus.job_count    = job_count_q;
    assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_modmul_stream_ctrl.sv
// Bench for modmul_stream_ctrl at WIDTH=16, TIMEOUT=8: directed steps plus random
// jobs, with expected tx bytes kept in a queue by a simple multiplier model.
`timescale 1ns/1ps
module tb_modmul_stream_ctrl;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 8;
  localparam int NB      = WIDTH / 8;

  logic clock = 1'b0;
  logic reset_all;
  always #5 clock = ~clock;

  modmul_stream_ctrl_if #(.WIDTH(WIDTH)) bus();

  modmul_stream_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .reset_all (reset_all),
    .bus       (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_jobs = 0;
  logic [7:0] exp_q[$];
  logic [15:0] x, y, q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  // Loads X then Y LSB-first; returns in the cycle after the last byte.
  task automatic load_job(input logic [15:0] jx, input logic [15:0] jy);
    for (int i = 0; i < NB; i++) send_byte(jx[8*i +: 8]);
    check("busy_after_x", bus.busy, 1);
    for (int i = 0; i < NB; i++) send_byte(jy[8*i +: 8]);
    check("issue_pulse", bus.mul_in_valid, 1);
    check("mul_x", bus.mul_x, jx);
    check("mul_y", bus.mul_y, jy);
  endtask

  // Multiplier model: returns jq after lat idle WAIT cycles.
  task automatic multiply(input logic [15:0] jq, input int lat, input bit inject);
    tick();
    check("issue_single", bus.mul_in_valid, 0);
    for (int i = 0; i < lat; i++) begin
      if (inject && i == 0) send_byte(8'hAA);
      else tick();
    end
    bus.mul_q = jq;
    bus.mul_out_valid = 1'b1;
    tick();
    bus.mul_out_valid = 1'b0;
    bus.mul_q = '0;
    for (int i = 0; i < NB; i++) exp_q.push_back(jq[8*i +: 8]);
    check("send_valid", bus.tx_valid, 1);
  endtask

  // mode 0: always ready; 1: ready pattern 0,0,1,0,1; 2: random ready.
  task automatic drain(input int mode);
    int n = 0;
    logic rdy;
    logic [4:0] pat = 5'b10100;
    while (exp_q.size() > 0 && n < 50) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = pat[n % 5];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.tx_ready = rdy;
      check("tx_valid", bus.tx_valid, 1);
      check("tx_data", bus.tx_data, exp_q[0]);
      tick();
      if (rdy) void'(exp_q.pop_front());
      n++;
    end
    bus.tx_ready = 1'b0;
    check("drain_budget", exp_q.size(), 0);
    exp_q.delete();
    exp_jobs++;
    check("done_tx_valid", bus.tx_valid, 0);
    check("done_busy", bus.busy, 0);
    check("job_count", bus.job_count, exp_jobs);
  endtask

  initial begin
    reset_all = 1'b1;
    bus.rx_data = '0;
    bus.rx_valid = 1'b0;
    bus.mul_out_valid = 1'b0;
    bus.mul_q = '0;
    bus.tx_ready = 1'b0;
    repeat (3) tick();
    check("rst_mul_x", bus.mul_x, 0);
    check("rst_mul_y", bus.mul_y, 0);
    check("rst_in_valid", bus.mul_in_valid, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_job_count", bus.job_count, 0);
    reset_all = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_tx_valid", bus.tx_valid, 0);
    end

    // Directed single job.
    load_job(16'h1234, 16'h5678);
    multiply(16'hBEEF, 4, 1'b0);
    drain(0);

    // Back-pressure.
    load_job(16'h1234, 16'h5678);
    multiply(16'hBEEF, 4, 1'b0);
    drain(1);

    // Overrun during WAIT.
    x = 16'($urandom); y = 16'($urandom);
    load_job(x, y);
    check("pre_overrun", bus.overrun, 0);
    multiply(16'((32'(x) * 32'(y)) % 32'hFFF1), 3, 1'b1);
    check("overrun_set", bus.overrun, 1);
    check("overrun_mul_x", bus.mul_x, x);
    check("overrun_mul_y", bus.mul_y, y);
    drain(0);
    check("overrun_sticky", bus.overrun, 1);

    // Timeout; a result offered during ISSUE must be ignored.
    x = 16'($urandom); y = 16'($urandom);
    load_job(x, y);
    bus.mul_q = 16'hDEAD;
    bus.mul_out_valid = 1'b1;
    tick();
    bus.mul_out_valid = 1'b0;
    bus.mul_q = '0;
    check("issue_result_ignored", bus.tx_valid, 0);
    check("wait_no_timeout", bus.timeout, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick();
      check("wait_busy", bus.busy, 1);
      check("wait_no_timeout", bus.timeout, 0);
    end
    tick();
    check("timeout_set", bus.timeout, 1);
    check("timeout_idle", bus.busy, 0);
    check("timeout_no_tx", bus.tx_valid, 0);
    check("timeout_jobs", bus.job_count, exp_jobs);

    // Random jobs after the timeout.
    for (int j = 0; j < 6; j++) begin
      x = 16'($urandom); y = 16'($urandom);
      load_job(x, y);
      multiply(16'((32'(x) * 32'(y)) % 32'hFFF1), $urandom_range(0, 6), 1'b0);
      drain(j == 0 ? 0 : 2);
    end
    check("timeout_sticky", bus.timeout, 1);

    // Reset in the middle of SEND.
    load_job(16'hA55A, 16'h0F0F);
    multiply(16'hC3D2, 2, 1'b0);
    bus.tx_ready = 1'b1;
    check("mid_first_byte", bus.tx_data, 8'hD2);
    tick();
    bus.tx_ready = 1'b0;
    check("mid_second_byte", bus.tx_data, 8'hC3);
    reset_all = 1'b1;
    tick();
    reset_all = 1'b0;
    check("mid_rst_tx_valid", bus.tx_valid, 0);
    check("mid_rst_tx_data", bus.tx_data, 0);
    check("mid_rst_jobs", bus.job_count, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_overrun", bus.overrun, 0);
    check("mid_rst_timeout", bus.timeout, 0);
    check("mid_rst_mul_x", bus.mul_x, 0);
    exp_q.delete();
    exp_jobs = 0;
    load_job(16'h0102, 16'h0304);
    multiply(16'h0708, 1, 1'b0);
    drain(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
